sqemux_dyn: RTL

Parametrised N-input quadrant-clock/enable selector with glitch-safe break-before-make switchover, the next generation of the two-input static quadrant mux. It sits between the N_IN candidate quadrant sources and the quadrant distribution buffer. It selects either statically, from the configuration select, or dynamically through a valid/ready request port. Every source change passes through a gated-off drain interval and a settle interval, so the output never shows a partial pulse from two sources.

---
 rtl/sqemux_pkg.sv | 23 ++
 rtl/sqemux_dyn_timer.sv | 28 ++
 rtl/sqemux_dyn.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sqemux_pkg.sv
// Shared types and helpers for the dynamic quadrant selector.
// The optional switch counter (SQEMUX_DYN_STATUS_EN) uses SW_CNT_W from here.
package sqemux_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam int SW_CNT_W = 16;
    localparam int MAX_N    = 16;

    // Callers truncate the result to their own source count.
    function automatic logic [MAX_N-1:0] onehot(input logic [3:0] idx);
        logic [MAX_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sqemux_dyn_timer.sv
// Loadable down-counter that times the DRAIN and SETTLE intervals.
// The done flag is high during the final cycle of the loaded interval.
module sqemux_dyn_timer #(
    parameter int MAX = 2,
    localparam int W = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/sqemux_dyn.sv
// N-input quadrant source selector with break-before-make switchover.
// Define SQEMUX_DYN_STATUS_EN to add CNT_CLR and the SW_CNT switch counter.
module sqemux_dyn
    import sqemux_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int GAP    = 2,
    parameter int SETTLE = 2,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_IN-1:0]  IN,
    input  logic             SEN,
    input  logic             DEN,
    input  logic [SEL_W-1:0] STATIC_SEL,
    input  logic             REQ_VLD,
    input  logic [SEL_W-1:0] REQ_SEL,
    output logic             REQ_RDY,
    output logic [N_IN-1:0]  GATE,
    output logic [SEL_W-1:0] SEL_Q,
    output logic             IZ,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output state_t           fsm_state
`ifdef SQEMUX_DYN_STATUS_EN
    ,
    input  logic                CNT_CLR,
    output logic [SW_CNT_W-1:0] SW_CNT
`endif
);

    localparam int MAX_T = (GAP > SETTLE) ? GAP : SETTLE;
    localparam int CNT_W = $clog2(MAX_T + 1);
    localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_IN);

    state_t           state, state_n;
    logic [SEL_W-1:0] sel_n, tgt, tgt_n;
    logic             sw_flag, sw_n;
    logic             t_load, t_done;
    logic [CNT_W-1:0] t_val;
    logic             noop_n, err_n, sw_done;
    logic [N_IN-1:0]  gate_n;
    logic             busy_n, done_n;
    logic             en, dyn_mode, stat_mode, req_in_range;

    // Dynamic enable outranks static enable.
    assign dyn_mode     = DEN;
    assign stat_mode    = !DEN && SEN;
    assign en           = DEN || SEN;
    assign req_in_range = ({1'b0, REQ_SEL} < N_LIM);
    assign REQ_RDY      = (state == ST_RUN) && DEN;
    assign fsm_state    = state;

    sqemux_dyn_timer #(.MAX(MAX_T)) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_OFF;
            SEL_Q   <= '0;
            tgt     <= '0;
            sw_flag <= 1'b0;
            GATE    <= '0;
            IZ      <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            state   <= state_n;
            SEL_Q   <= sel_n;
            tgt     <= tgt_n;
            sw_flag <= sw_n;
            GATE    <= gate_n;
            IZ      <= |(IN & GATE);
            BUSY    <= busy_n;
            DONE    <= done_n;
            ERR     <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = SEL_Q;
        tgt_n   = tgt;
        sw_n    = sw_flag;
        t_load  = 1'b0;
        t_val   = CNT_W'(SETTLE);
        noop_n  = 1'b0;
        err_n   = 1'b0;
        if (!en) begin
            // Disabling drops any in-flight target without touching SEL_Q in DRAIN.
            state_n = ST_OFF;
            sw_n    = 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_n = ST_SETTLE;
                    sw_n    = 1'b0;
                    t_load  = 1'b1;
                    t_val   = CNT_W'(SETTLE);
                    if (stat_mode) sel_n = STATIC_SEL;
                end
                ST_RUN: begin
                    if (dyn_mode) begin
                        if (REQ_VLD) begin
                            if (!req_in_range) begin
                                err_n = 1'b1;
                            end else if (REQ_SEL == SEL_Q) begin
                                noop_n = 1'b1;
                            end else begin
                                tgt_n   = REQ_SEL;
                                state_n = ST_DRAIN;
                                t_load  = 1'b1;
                                t_val   = CNT_W'(GAP);
                            end
                        end
                    end else if (STATIC_SEL != SEL_Q) begin
                        tgt_n   = STATIC_SEL;
                        state_n = ST_DRAIN;
                        t_load  = 1'b1;
                        t_val   = CNT_W'(GAP);
                    end
                end
                ST_DRAIN: begin
                    if (t_done) begin
                        sel_n   = tgt;
                        sw_n    = 1'b1;
                        state_n = ST_SETTLE;
                        t_load  = 1'b1;
                        t_val   = CNT_W'(SETTLE);
                    end
                end
                ST_SETTLE: begin
                    if (t_done) state_n = ST_RUN;
                end
                default: state_n = ST_OFF;
            endcase
        end
    end

    always_comb begin
        gate_n  = (state_n == ST_RUN) ? N_IN'(onehot(4'(sel_n))) : '0;
        busy_n  = (state_n == ST_DRAIN) || (state_n == ST_SETTLE);
        sw_done = (state == ST_SETTLE) && (state_n == ST_RUN) && sw_flag;
        done_n  = sw_done || noop_n;
    end

`ifdef SQEMUX_DYN_STATUS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SW_CNT <= '0;
        end else if (CNT_CLR) begin
            SW_CNT <= '0;
        end else if (sw_done && (SW_CNT != '1)) begin
            SW_CNT <= SW_CNT + SW_CNT_W'(1);
        end
    end
`endif

endmodule
